// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//   Byte-oriented SPI master. Moves one WIDTH-bit word in each direction per
//   transaction, LSB first, with spi_clk derived from sclk by a programmable
//   half-period divider. Host side uses a start / busy / done handshake.
//
// Parameters
//   CLK_DIV : half-period of spi_clk in sclk cycles (>= 1)
//   WIDTH   : bits per transaction
//
// Ports
//   sclk     in          system clock, rising edge
//   reset    in          synchronous, active-low reset
//   start    in          transaction request, honoured only in IDLE
//   tx_data  in  [WIDTH] word to send, latched on acceptance
//   miso     in          serial data from slave
//   spi_clk  out         serial clock, idles low
//   cs       out         chip select, active-low, idles high
//   mosi     out         serial data to slave, LSB first
//   rx_data  out [WIDTH] last received word, held until the next done
//   busy     out         high while a transaction is in progress
//   done     out         one-cycle pulse at transaction end
// -----------------------------------------------------------------------------
module spi_master #(
  parameter int CLK_DIV = 2,
  parameter int WIDTH   = 8
) (
  input  logic             sclk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             miso,
  output logic             spi_clk,
  output logic             cs,
  output logic             mosi,
  output logic [WIDTH-1:0] rx_data,
  output logic             busy,
  output logic             done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_n;
  logic [WIDTH-1:0] tx_shift, tx_shift_n;
  logic [WIDTH-1:0] rx_shift, rx_shift_n;
  logic [WIDTH-1:0] rx_data_n;
  logic             spi_clk_n, cs_n, mosi_n, busy_n, done_n;

  // Every phase (SETUP, HIGH, LOW, HOLD) lasts exactly CLK_DIV sclk cycles.
  logic             div_end;
  logic [WIDTH-1:0] tx_next;

  assign div_end = (div_cnt == DIV_MAX);
  assign tx_next = tx_shift >> 1;

  // NOTE: synchronous reset -- reset is only looked at on the sclk edge, so it
  // sits inside the clocked branch rather than in the sensitivity list.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge sclk) begin
    if (!reset) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      spi_clk  <= 1'b0;
      cs       <= 1'b1;
      mosi     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_cnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_shift <= tx_shift_n;
      rx_shift <= rx_shift_n;
      rx_data  <= rx_data_n;
      spi_clk  <= spi_clk_n;
      cs       <= cs_n;
      mosi     <= mosi_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    div_cnt_n  = div_cnt;
    bit_cnt_n  = bit_cnt;
    tx_shift_n = tx_shift;
    rx_shift_n = rx_shift;
    rx_data_n  = rx_data;
    spi_clk_n  = spi_clk;
    cs_n       = cs;
    mosi_n     = mosi;
    busy_n     = busy;
    done_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          tx_shift_n = tx_data;
          rx_shift_n = '0;
          bit_cnt_n  = '0;
          div_cnt_n  = '0;
          cs_n       = 1'b0;
          mosi_n     = tx_data[0];
          busy_n     = 1'b1;
          state_n    = SETUP;
        end
      end

      SETUP, LOW: begin
        if (div_end) begin
          div_cnt_n = '0;
          spi_clk_n = 1'b1;
          state_n   = HIGH;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      HIGH: begin
        if (div_end) begin
          div_cnt_n  = '0;
          spi_clk_n  = 1'b0;
          // Falling edge: capture MISO half a period after the slave moved it.
          rx_shift_n = {miso, rx_shift[WIDTH-1:1]};
          bit_cnt_n  = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_n = HOLD;
          end else begin
            tx_shift_n = tx_next;
            mosi_n     = tx_next[0];
            state_n    = LOW;
          end
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      HOLD: begin
        if (div_end) begin
          div_cnt_n = '0;
          cs_n      = 1'b1;
          mosi_n    = 1'b0;
          rx_data_n = rx_shift;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          state_n   = IDLE;
        end else begin
          div_cnt_n = div_cnt + 1'b1;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/spi_master.md
# spi_master

Byte-oriented SPI master: the initiating end of the team's SPI link, driving chip-select, serial clock and MOSI toward `spi_slave` and capturing its MISO. It runs from the system clock `sclk` and derives the serial clock by a programmable divider. A start/busy/done handshake moves one LSB-first byte in each direction per transaction. It sits between the host control logic and the SPI pins, and serves as the stimulus-side counterpart in slave verification.

## Interface
- `CLK_DIV`, default 2: half-period of `spi_clk` in `sclk` cycles; legal range ≥1.
- `WIDTH`, default 8: bits per transaction.

Ports:
- `sclk` in 1: system clock; all logic on its rising edge.
- `reset` in 1: reset, synchronous, active-low.
- `start` in 1: transaction request, sampled only in IDLE.
- `tx_data` in WIDTH: byte to send, latched when `start` is accepted.
- `miso` in 1: serial data from slave.
- `spi_clk` out 1: serial clock, idles low.
- `cs` out 1: chip select, active-low, idles high.
- `mosi` out 1: serial data to slave, LSB first.
- `rx_data` out WIDTH: last received byte, held until the next `done`.
- `busy` out 1: high while a transaction is in progress.
- `done` out 1: one-cycle pulse at transaction end.

## Operation
- All outputs registered. Reset (`reset`=0 at a `sclk` edge) forces: state IDLE, `cs`=1, `spi_clk`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0, divider and bit counters=0.
- Bit order is LSB first both ways. Each receive shift is rx_shift ← {miso, rx_shift[WIDTH-1:1]}, matching the slave's shift direction.
- States:
  - IDLE: `start`=1 latches `tx_data` into tx_shift, clears rx_shift and bit_cnt, drives `cs`=0, `mosi`=tx_data[0], `busy`=1. Next state SETUP.
  - SETUP: `spi_clk`=0 for CLK_DIV cycles. Then `spi_clk`←1 and go to HIGH.
  - HIGH: `spi_clk`=1 for CLK_DIV cycles. Then `spi_clk`←0, sample `miso` into rx_shift, bit_cnt+1.
    - If the sampled bit was bit WIDTH-1: go to HOLD.
    - Otherwise: `mosi`←next tx bit and go to LOW.
  - LOW: `spi_clk`=0 for CLK_DIV cycles. Then `spi_clk`←1 and go to HIGH.
  - HOLD: `cs`=0, `spi_clk`=0 for CLK_DIV cycles. Then `cs`←1, `mosi`←0, `rx_data`←rx_shift, `done`←1, `busy`←0. Next state IDLE.
- `done` clears on the following cycle.
- `start` is ignored while `busy`=1. It is not queued.
- `tx_data` changes after acceptance have no effect.
- The slave samples MOSI on the `spi_clk` rising edge; the master samples MISO on the falling edge, one half-period after the slave updates it.

## Timing
- Let D=CLK_DIV and edge 0 be the `sclk` edge that accepts `start`.
- `cs` falls and `busy` rises at edge 0.
- `spi_clk` for bit k (k=0..WIDTH-1):
  - rises at edge D+2kD;
  - falls at edge 2D+2kD, when MISO bit k is sampled and `mosi` moves to bit k+1.
- Last fall at edge 2·WIDTH·D.
- At edge (2·WIDTH+1)·D: `cs` rises, `done`=1, `rx_data` valid, `busy`=0. For WIDTH=8, D=2 this is edge 34.
- `mosi` is stable for ≥D cycles before every rising edge.
- Back-to-back transfers: `start` held high re-accepts on the edge after `done`, so `cs` is high for exactly 1 cycle between transactions.
- Reset mid-transfer: outputs return to reset values at that edge, no `done` pulse, `rx_data` cleared.

## Test plan
- D=2, `tx_data`=0xA5, slave model returns 0x3C → `mosi` at rising edges reads 1,0,1,0,0,1,0,1; `spi_clk` rises at edges 2,6,…,30; `done` at edge 34; `rx_data`=0x3C.
- D=1, `tx_data`=0xFF, MISO tied 0 → `done` at edge 17, `rx_data`=0x00, exactly 8 `spi_clk` pulses each 1 cycle high.
- `start` pulsed at edges 5 and 20 during a D=2 transfer → ignored; a single `done`; `tx_data` change after edge 0 has no effect on `mosi`.
- `start` held high for two transactions (0x01 then 0x80) → `cs` high exactly 1 cycle between them; `rx_data` updates at each `done`.
- `reset`=0 at edge 12 mid-transfer → `cs`=1, `spi_clk`=0, `busy`=0, `rx_data`=0 at edge 12; no `done`; a new `start` afterward completes normally.
- Loopback against `spi_slave` (slave loaded with 0x5A, master sends 0xC3) → master `rx_data`=0x5A; slave receives 0xC3.
